// File: rtl/regfile_snapshot.sv
// regfile_snapshot: walks x0..x(NREGS-1) through one regfile read port and streams each value
// over valid/ready to the difftest checker, holding writeback for the whole snapshot.
module regfile_snapshot #(
    parameter int unsigned REG_W = 64,
    parameter int unsigned NREGS = 32,
    localparam int unsigned IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snap_req,
    output logic             snap_busy,
    output logic             snap_hold,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [REG_W-1:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [REG_W-1:0] out_data,
    output logic             out_last,
    output logic             snap_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               rd_en_q;
    logic [IDX_W-1:0]   rd_addr_q;
    logic               valid_q;
    logic               last_q;
    logic               done_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [REG_W-1:0]   data_q;

    // Every output flop is loaded with the value it must show in the state being entered,
    // so nothing downstream sees a combinational path from out_ready or snap_req.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            out_idx_q <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (snap_req) begin
                        state_q   <= StRead;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                StRead: begin
                    data_q    <= rd_data;
                    out_idx_q <= idx_q;
                    last_q    <= (idx_q == LAST_IDX);
                    valid_q   <= 1'b1;
                    rd_en_q   <= 1'b0;
                    rd_addr_q <= '0;
                    state_q   <= StSend;
                end
                StSend: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= idx_q + 1'b1;
                            state_q   <= StRead;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    rd_en_q   <= 1'b0;
                    rd_addr_q <= '0;
                    valid_q   <= 1'b0;
                    last_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign snap_busy = busy_q;
    assign snap_hold = busy_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign snap_done = done_q;

endmodule

// File: tb/tb_regfile_snapshot.sv
// Bench for regfile_snapshot: a behavioural regfile with stallW, plus a word-queue model of
// the expected stream and its cycle timing.
module tb_regfile_snapshot;

    localparam int unsigned REG_W = 64;
    localparam int unsigned NREGS = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             snap_req;
    logic             snap_busy;
    logic             snap_hold;
    logic             rd_en;
    logic [4:0]       rd_addr;
    logic [REG_W-1:0] rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_idx;
    logic [REG_W-1:0] out_data;
    logic             out_last;
    logic             snap_done;

    // Regfile and its writeback port, stalled by snap_hold.
    logic [REG_W-1:0] rf [NREGS];
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [REG_W-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    // Reference model: pending words of the current snapshot and when things are due.
    int               cyc = 0;
    bit               active = 1'b0;
    bit               start_pending = 1'b0;
    int               next_valid = 0;
    int               done_cyc = -1;
    logic [4:0]       q_idx [$];
    logic [REG_W-1:0] q_data [$];

    always #5 clk = ~clk;

    assign rd_data = (rd_en && rd_addr != 5'd0) ? rf[rd_addr] : '0;

    regfile_snapshot #(
        .REG_W (REG_W),
        .NREGS (NREGS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .snap_req  (snap_req),
        .snap_busy (snap_busy),
        .snap_hold (snap_hold),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .snap_done (snap_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h required %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(snap_busy), 64'd0);
        chk({tag, "_hold"}, 64'(snap_hold), 64'd0);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_done"}, 64'(snap_done), 64'd0);
        chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model, then apply
    // any writeback that stallW let through just after the rising edge.
    task automatic cycle();
        bit         ev;
        bit         erd;
        bit         do_wb;
        logic [4:0] front;
        @(negedge clk);
        front = (q_idx.size() > 0) ? q_idx[0] : 5'd0;
        ev  = active && q_idx.size() > 0 && cyc >= next_valid;
        erd = active && q_idx.size() > 0 && cyc == next_valid - 1;
        chk("busy", 64'(snap_busy), 64'(active));
        chk("hold", 64'(snap_hold), 64'(active));
        chk("valid", 64'(out_valid), 64'(ev));
        chk("rd_en", 64'(rd_en), 64'(erd));
        chk("rd_addr", 64'(rd_addr), erd ? 64'(front) : 64'd0);
        chk("done", 64'(snap_done), 64'(cyc == done_cyc));
        chk("last", 64'(out_last), 64'(ev && front == 5'(NREGS - 1)));
        if (ev) begin
            chk("out_idx", 64'(out_idx), 64'(front));
            chk("out_data", out_data, q_data[0]);
        end
        do_wb = wb_en && !snap_hold && wb_addr != 5'd0;
        if (ev && out_ready) begin
            void'(q_idx.pop_front());
            void'(q_data.pop_front());
            if (q_idx.size() == 0) done_cyc = cyc + 1;
            else next_valid = cyc + 2;
        end
        if (cyc == done_cyc) begin
            active = 1'b0;
        end else if (!active && snap_req && rst) begin
            active        = 1'b1;
            start_pending = 1'b1;
            next_valid    = cyc + 2;
        end
        @(posedge clk);
        #1;
        if (do_wb) rf[wb_addr] = wb_data;
        if (start_pending) begin
            q_idx.delete();
            q_data.delete();
            for (int i = 0; i < NREGS; i++) begin
                q_idx.push_back(5'(i));
                q_data.push_back(i == 0 ? '0 : rf[i]);
            end
            start_pending = 1'b0;
        end
        cyc++;
    endtask

    // Issue a request and run until the model says the snapshot is over.
    task automatic run_snapshot(input bit rand_ready, input int poke_word, input bit wb_during);
        int k;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        wb_en    = wb_during;
        k = 0;
        while (active && k < 1000) begin
            out_ready = rand_ready ? 1'(($urandom % 2) == 1) : 1'b1;
            snap_req  = 1'(poke_word >= 0 &&
                           ((q_idx.size() > 0 && q_idx[0] == 5'(poke_word)) || cyc == done_cyc));
            cycle();
            k++;
        end
        snap_req  = 1'b0;
        wb_en     = 1'b0;
        out_ready = 1'b1;
        checks++;
        assert (!active) else begin
            errors++;
            $error("FAIL snapshot_timeout @cyc %0d: observed active required idle", cyc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        snap_req  = 1'b0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = '0;
        for (int i = 0; i < NREGS; i++) rf[i] = (i == 0) ? '0 : 64'h1000 + 64'(i);
        #2 rst = 1'b0;
        #1 chk_all_zero("reset");
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // Full dump with out_ready held high.
        run_snapshot(1'b0, -1, 1'b0);
        repeat (2) cycle();

        // Writeback of x5 attempted throughout; the stall must keep the old value.
        wb_addr = 5'd5;
        wb_data = 64'hDEAD;
        run_snapshot(1'b0, -1, 1'b1);
        chk("x5_unwritten", rf[5], 64'h1005);
        repeat (2) cycle();

        // Back-pressure over random register contents.
        for (int i = 1; i < NREGS; i++) rf[i] = {$urandom, $urandom};
        run_snapshot(1'b1, -1, 1'b0);
        repeat (2) cycle();

        // Extra requests at word 10 and in the DONE cycle are ignored.
        run_snapshot(1'b1, 10, 1'b0);
        repeat (3) cycle();

        // Asynchronous reset while word 17 is being fetched.
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        for (int k = 0; k < 200 && !(q_idx.size() > 0 && q_idx[0] == 5'd17); k++) cycle();
        #2 rst = 1'b0;
        #1 chk_all_zero("mid_reset");
        active = 1'b0;
        start_pending = 1'b0;
        done_cyc = -1;
        q_idx.delete();
        q_data.delete();
        snap_req = 1'b1;
        repeat (3) cycle();
        snap_req = 1'b0;
        rst = 1'b1;
        repeat (2) cycle();
        run_snapshot(1'b0, -1, 1'b0);

        // Idle quiescence.
        repeat (100) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_snapshot.md
# regfile_snapshot

Sequential reader for the 32 x 64-bit integer register file. On request it stalls writeback, reads every architectural register x0..x31 in order through one regfile read port, and streams each value out over a valid/ready handshake to the difftest commit/checker logic. It sits beside the writeback stage and shares a read port with decode through a mux controlled by `snap_busy`.

## Interface
- `REG_W`, 64: register data width.
- `NREGS`, 32: number of registers streamed; index width is 5 bits.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `snap_req` input 1: start request. Sampled only in IDLE.
- `snap_busy` output 1: high in every state except IDLE.
- `snap_hold` output 1: equals `snap_busy`. The pipeline must hold writeback (stallW) while it is high.
- `rd_en` output 1: regfile read-enable.
- `rd_addr` output 5: regfile read address.
- `rd_data` input REG_W: regfile read data. Combinational; valid in the same cycle as `rd_addr`.
- `out_valid` output 1: stream word valid.
- `out_ready` input 1: consumer accepts the word.
- `out_idx` output 5: register index of the current word.
- `out_data` output REG_W: register value.
- `out_last` output 1: high with the word for index NREGS-1.
- `snap_done` output 1: one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE
  - READ: `rd_en`=1, `rd_addr`=idx. `rd_data` is registered into `out_data`/`out_idx` at the clock edge, then go to SEND.
  - SEND: `out_valid`=1. When `out_ready` is high, either set idx=idx+1 and go to READ, or, if idx==NREGS-1, go to DONE.
  - DONE: `snap_done`=1 for one cycle, then go to IDLE.
- IDLE to READ when `snap_req`=1. idx is cleared to 0 on that transition.
- `snap_req` is ignored in all non-IDLE states: no queuing, no restart.
- `out_data`, `out_idx` and `out_last` are registered. They must not change while `out_valid`=1 and `out_ready`=0.
- `out_last` = (`out_idx`==NREGS-1) while `out_valid` is high; 0 otherwise.
- x0 is read like any other index. The regfile returns 0, so word 0 must be 0.
- idx is a 5-bit counter. It never wraps inside a snapshot, because SEND exits at index 31.
- `rd_en`/`rd_addr` are 0 in all states other than READ.
- Reset values (`rst` low, asynchronous): state IDLE, idx 0, `out_data` 0, `out_idx` 0.
  - Outputs under reset: `out_valid`, `out_last`, `snap_busy`, `snap_hold`, `rd_en`, `snap_done` all 0; `rd_addr` 0.
- Reset asserted mid-snapshot aborts the snapshot immediately. No `snap_done` is produced, and the stream restarts at index 0 on the next request.

## Timing
- `snap_req` sampled high in cycle T:
  - `snap_busy`/`snap_hold` are high from T+1.
  - READ for index 0 occurs in T+1.
  - `out_valid` is high from T+2.
- Each word costs 2 cycles minimum (READ + SEND) with `out_ready` held at 1.
- The full 32-register snapshot completes in 64 cycles from the first READ. `snap_done` is high in cycle T+65, and `snap_busy` is low from T+66.
- Each SEND cycle with `out_ready`=0 adds one cycle to the total.
- `snap_busy`, `snap_hold`, `out_valid`, `out_last` and `rd_en` decode from state/registered values only. `snap_hold` has no combinational path from `out_ready` or `snap_req`.
- A new request in the cycle DONE exits is ignored. A request is accepted only when the state is IDLE at the sampling edge.

## Test plan
- Full dump: preload regs xi = 0x1000+i (x0=0), pulse `snap_req`, hold `out_ready`=1.
  - 32 words, idx 0..31, data 0, 0x1001..0x101F.
  - `out_last` only on idx 31.
  - `snap_done` at T+65.
- Back-pressure: toggle `out_ready` pseudo-randomly.
  - `out_data`/`out_idx` stay stable while stalled.
  - No word is lost or duplicated; the order is preserved.
- Request while busy: pulse `snap_req` again at word 10.
  - The sequence is unaffected.
  - Exactly one `snap_done`, and no second snapshot starts.
- Hold check: attempt a writeback of x5=0xDEAD during the snapshot.
  - `snap_hold`=1 throughout, so stallW blocks the write.
  - Word 5 still reads the preloaded value 0x1005.
- Reset mid-snapshot: drop `rst` at word 17.
  - All outputs are 0 immediately (asynchronous) and there is no `snap_done`.
  - After release, a new request streams from idx 0.
- Idle quiescence: no `snap_req` for 100 cycles.
  - `rd_en`, `out_valid`, `snap_busy` and `snap_done` remain 0.
